// File: rtl/tty_output_fifo.sv
// Console-side byte FIFO that drains to the text console on tty_busy and emits ESC clear/home sequences.
// Optional: define TTY_OUTPUT_FIFO_DROP_COUNT_EN to add a saturating drop_count output.
module tty_output_fifo #(
    parameter int         ADDR_WIDTH = 4,
    parameter logic [7:0] ESC_CHAR   = 8'h1B
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_write,
    input  logic [7:0]            in_data,
    output logic                  in_full,
    input  logic                  cmd_clear,
    input  logic                  cmd_home,
    output logic                  cmd_busy,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
`ifdef TTY_OUTPUT_FIFO_DROP_COUNT_EN
    output logic [15:0]           drop_count,
`endif
    output logic                  tty_write,
    output logic [7:0]            tty_data,
    input  logic                  tty_busy
);

    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [7:0]          CHAR_R  = 8'h52;
    localparam logic [7:0]          CHAR_LB = 8'h5B;
    localparam logic [7:0]          CHAR_H  = 8'h48;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_SEQ
    } state_t;

    state_t              r_state;
    logic [7:0]          r_mem [DEPTH];
    logic [ADDR_WIDTH:0] r_wrPtr;
    logic [ADDR_WIDTH:0] r_rdPtr;
    logic                r_overflow;
    logic                r_cmdBusy;
    logic                r_cmdHome;
    logic [1:0]          r_seqIdx;
    logic                r_ttyWrite;
    logic [7:0]          r_ttyData;

    logic [ADDR_WIDTH:0] w_count;
    logic                w_fifoFull;
    logic                w_fifoEmpty;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;

    // Count never exceeds DEPTH, so its MSB alone marks the full condition.
    assign w_count     = r_wrPtr - r_rdPtr;
    assign w_fifoFull  = w_count[ADDR_WIDTH];
    assign w_fifoEmpty = (w_count == '0);
    assign in_full     = w_fifoFull | r_cmdBusy;
    assign w_push      = in_write & ~in_full;
    assign w_drop      = in_write & in_full;
    assign w_pop       = (r_state == S_IDLE) & ~tty_busy & ~w_fifoEmpty;

    assign fifo_count  = w_count;
    assign overflow    = r_overflow;
    assign cmd_busy    = r_cmdBusy;
    assign tty_write   = r_ttyWrite;
    assign tty_data    = r_ttyData;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr[ADDR_WIDTH-1:0]] <= in_data;
    end

    // GAP exists because tty_busy only reflects a consumed byte one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ttyWrite <= 1'b0;
            r_ttyData  <= 8'h00;
            r_seqIdx   <= 2'd0;
            r_cmdBusy  <= 1'b0;
            r_cmdHome  <= 1'b0;
        end else begin
            if (!r_cmdBusy && (cmd_clear || cmd_home)) begin
                r_cmdBusy <= 1'b1;
                r_cmdHome <= ~cmd_clear;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_ttyWrite <= 1'b1;
                        r_ttyData  <= r_mem[r_rdPtr[ADDR_WIDTH-1:0]];
                        r_seqIdx   <= 2'd0;
                        r_state    <= S_GAP;
                    end else if (!tty_busy && r_cmdBusy) begin
                        r_ttyWrite <= 1'b1;
                        r_ttyData  <= ESC_CHAR;
                        r_seqIdx   <= 2'd1;
                        r_state    <= S_GAP;
                    end else begin
                        r_ttyWrite <= 1'b0;
                    end
                end
                S_GAP: begin
                    r_ttyWrite <= 1'b0;
                    r_state    <= (r_seqIdx == 2'd0) ? S_IDLE : S_SEQ;
                end
                S_SEQ: begin
                    if (!tty_busy) begin
                        r_ttyWrite <= 1'b1;
                        r_state    <= S_GAP;
                        if (!r_cmdHome) begin
                            r_ttyData <= CHAR_R;
                            r_seqIdx  <= 2'd0;
                            r_cmdBusy <= 1'b0;
                        end else if (r_seqIdx == 2'd1) begin
                            r_ttyData <= CHAR_LB;
                            r_seqIdx  <= 2'd2;
                        end else begin
                            r_ttyData <= CHAR_H;
                            r_seqIdx  <= 2'd0;
                            r_cmdBusy <= 1'b0;
                        end
                    end else begin
                        r_ttyWrite <= 1'b0;
                    end
                end
                default: begin
                    r_ttyWrite <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TTY_OUTPUT_FIFO_DROP_COUNT_EN
    logic [15:0] r_dropCount;
    assign drop_count = r_dropCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dropCount <= 16'h0000;
        end else if (w_drop && (r_dropCount != 16'hFFFF)) begin
            r_dropCount <= r_dropCount + 16'h0001;
        end
    end
`endif

endmodule

// File: doc/tty_output_fifo.md
Name: tty_output_fifo

Overview:
- Initiator side of the text-console tty byte interface (tty_write / tty_data / tty_busy).
- Buffers bytes posted by the CPU bus bridge in a FIFO and drains them to the VGA text console, pacing on tty_busy.
- Also generates the console escape sequences on request: clear (ESC 'R') and home (ESC '[' 'H').
- Sits between the memory-mapped UART/console register block and the text console, in the console clock domain.

Parameters:
- ADDR_WIDTH, 4, log2 of FIFO depth (depth = 16).
- ESC_CHAR, 8'h1B, escape byte.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_write  input  1  enqueue in_data this cycle.
- in_data  input  8  byte to enqueue.
- in_full  output  1  FIFO cannot accept a byte.
- cmd_clear  input  1  request clear-screen sequence.
- cmd_home  input  1  request cursor-home sequence.
- cmd_busy  output  1  a command is pending or being sent.
- fifo_count  output  ADDR_WIDTH+1  bytes currently queued.
- overflow  output  1  sticky: a write was dropped.
- tty_write  output  1  one-cycle byte strobe to the console.
- tty_data  output  8  byte accompanying tty_write.
- tty_busy  input  1  console not ready; sampled only as described below.

Behaviour:
- Reset values: tty_write=0, tty_data=0, in_full=0, cmd_busy=0, fifo_count=0, overflow=0. FIFO pointers cleared and FSM in IDLE.
- Reset is not gated by anything. A partially sent escape sequence is abandoned; the console is reset by the same system reset.
- FIFO: circular buffer with pointers of width ADDR_WIDTH+1.
  - fifo_count = wr_ptr - rd_ptr.
  - Full when count == 2^ADDR_WIDTH.
  - Pointer wrap is via natural overflow.
- in_full = FIFO full OR cmd_busy. Blocking on a pending command preserves ordering: bytes enqueued after the command are sent after its sequence.
- in_write while in_full: byte dropped, overflow set to 1. overflow clears only on reset.
- Simultaneous in_write and dequeue with the FIFO full: the write is dropped (in_full is registered-state based).
- Command accept: when cmd_busy=0 and cmd_clear or cmd_home is high, latch the command and set cmd_busy=1 next cycle.
  - If both are high, clear wins and home is discarded.
  - Commands while cmd_busy=1 are ignored.
  - in_write in the same cycle as a command accept is enqueued ahead of the command.
- Pacing rule: the console's tty_busy reflects a consumed byte only one cycle after consumption. The block therefore never samples tty_busy in the cycle immediately after a strobe.
- Drain FSM:
  - IDLE:
    - If tty_busy=0 and the FIFO is non-empty: register tty_write=1, tty_data=head byte, pop; go to GAP.
    - Else if tty_busy=0, FIFO empty and a command is latched: register tty_write=1, tty_data=ESC_CHAR; go to GAP with seq_idx=1.
    - Otherwise stay in IDLE with tty_write=0.
  - GAP: tty_write=0 and tty_busy is ignored. Next state:
    - seq_idx==0 → IDLE.
    - Otherwise → SEQ.
  - SEQ: when tty_busy=0, emit the next sequence byte and go to GAP.
    - Clear: 'R' (8'h52), then seq_idx=0.
    - Home: '[' (8'h5B) then 'H' (8'h48).
    - After the final byte, clear the command latch. cmd_busy falls on the cycle the final byte's tty_write is high.
- Throughput: at most 1 byte per 2 cycles. Latency from in_write into an empty FIFO with tty_busy=0 to tty_write=1 is 2 cycles.
- tty_write is high for exactly one cycle per byte. tty_data holds its last value while tty_write=0.
- Data bytes equal to ESC_CHAR are passed through unmodified.

Optional Feature:
- Macro: TTY_OUTPUT_FIFO_DROP_COUNT_EN.
- Defined: adds output drop_count [15:0].
  - Increments on every dropped in_write and saturates at 16'hFFFF.
  - Reset value 0.
  - overflow still behaves as above.
- Undefined: drop_count port and its counter are absent; all other behaviour is identical.

Test Plan:
- After reset, tty_busy=0, write 8'h41 once → fifo_count reads 1 for one cycle, tty_write pulses 1 cycle with tty_data=8'h41, then fifo_count=0.
- tty_busy=1, write bytes 0x00..0x0F, then write 0x99 → in_full=1 after the 16th byte, overflow=1, 0x99 never appears. Release tty_busy → 16 strobes in order, at least 2 cycles apart.
- cmd_home with the FIFO holding "AB" → tty sequence 41, 42, 1B, 5B, 48. in_full=1 until 48 is sent; an in_write during this time is dropped.
- cmd_clear and cmd_home in the same cycle → only 1B, 52 emitted; cmd_busy then returns to 0.
- Raise tty_busy in the cycle after a strobe (console scroll model) for 5 cycles → no strobe until tty_busy=0 is sampled in IDLE.
- Assert reset mid home sequence (after 1B) → tty_write=0 next cycle, fifo_count=0, cmd_busy=0, overflow=0. With the macro defined, drop_count=0.
